// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one registered full-adder cell, LSB first; optional subtract via SERIAL_ADDER_SUB_EN.
// Latency: out_valid rises exactly WIDTH edges after the accepting edge; initiation interval WIDTH+2.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, inputs ignored otherwise.
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cell_s, cell_c;
    logic               sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = in_sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign cell_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign cell_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is a + ~b + 1, so the carry-out doubles as "no borrow".
                    a_sr_d  = in_a;
                    b_sr_d  = in_b ^ {WIDTH{sub_sel}};
                    carry_d = sub_sel ? 1'b1 : in_cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = cell_c;
                res_d   = {cell_s, res_q[WIDTH-1:1]};
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {cell_s, res_q[WIDTH-1:1]};
                    cout_d  = cell_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8); subtract steps only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       in_cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       busy;
`ifdef SERIAL_ADDER_SUB_EN
    logic       in_sub = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .in_sub   (in_sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until out_valid, bounded so a stuck DUT still reaches the summary.
    task automatic wait_result(input string tag, input int exp_lat);
        int cyc = 0;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic cin, input string tag);
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_in_ready"}, in_ready, 1);
        check({tag, "_idle_out_valid"}, out_valid, 0);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] es, input logic ec, input string tag);
        accept(a, b, cin, tag);
        check({tag, "_busy"}, busy, 1);
        wait_result(tag, 8);
        check({tag, "_sum"}, out_sum, es);
        check({tag, "_cout"}, out_cout, ec);
        handshake(tag);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_cout", out_cout, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // Basic additions
        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");

        // Back-pressure: result and flags stay put while out_ready is low
        accept(8'h12, 8'h34, 1'b0, "bp");
        wait_result("bp", 8);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_sum", out_sum, 8'h46);
            check("bp_hold_cout", out_cout, 0);
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_out_valid", out_valid, 1);
            step();
        end
        handshake("bp");

        // in_valid held high with new operands: ignored until after the output handshake
        accept(8'h80, 8'h80, 1'b0, "hold");
        in_valid = 1'b1;
        in_a = 8'h11;
        in_b = 8'h22;
        step();
        check("hold_run_in_ready", in_ready, 0);
        wait_result("hold", 7);
        check("hold_sum", out_sum, 8'h00);
        check("hold_cout", out_cout, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold_idle_busy", busy, 0);
        check("hold_idle_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("hold_second_busy", busy, 1);
        wait_result("hold_second", 8);
        check("hold_second_sum", out_sum, 8'h33);
        check("hold_second_cout", out_cout, 0);
        handshake("hold_second");

        // Reset mid-RUN after three processed bits
        accept(8'h0F, 8'h0F, 1'b0, "abort");
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        step();
        #3;
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (out_valid) seen++;
            end
            check("abort_no_result", seen, 0);
        end
        check("abort_release_in_ready", in_ready, 1);
        run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "post_abort");

`ifdef SERIAL_ADDER_SUB_EN
        in_sub = 1'b1;
        run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, "sub_10_01");
        run_op(8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, "sub_01_02");
        in_sub = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
